// File: rtl/gearbox_pkg.sv
// Shared definitions for the gearbox input-side feed controller.
//   WORD_W      : width of a word entering the gearbox
//   GB_OUT_W    : width of a word leaving the gearbox
//   *_WORD_DEF  : default training / sync / idle patterns
//   feed_state_e: scheduler states
package gearbox_pkg;

  localparam int WORD_W   = 16;
  localparam int GB_OUT_W = 20;

  localparam logic [WORD_W-1:0] TRAIN_WORD_DEF = 16'hBC50;
  localparam logic [WORD_W-1:0] SYNC_WORD_DEF  = 16'h7E7E;
  localparam logic [WORD_W-1:0] IDLE_WORD_DEF  = 16'h0000;

  typedef enum logic [1:0] {
    ST_TRAIN = 2'd0,
    ST_ARB   = 2'd1,
    ST_BURST = 2'd2
  } feed_state_e;

endpackage

// File: rtl/gearbox_rr_arb.sv
// Two-way round-robin arbiter with frame-granular memory.
//   clk1, res_n : clock, asynchronous active-low reset
//   req         : request vector {req1, req0}
//   done        : owner's frame finished this cycle
//   done_id     : index (0/1) of the requester whose frame finished
//   pick        : one-hot winner among current requests, 0 when none
module gearbox_rr_arb (
  input  logic       clk1,
  input  logic       res_n,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       done_id,
  output logic [1:0] pick
);

  // Index of the requester that owned the most recent completed frame.
  // Resets to 1 so requester 0 wins the first tie.
  logic last_grant;

  always_ff @(posedge clk1 or negedge res_n) begin
    if (!res_n) begin
      last_grant <= 1'b1;
    end else if (done) begin
      last_grant <= done_id;
    end
  end

  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/gearbox_feed_ctrl.sv
// Input-clock-side scheduler for the 16-to-20 bit gearbox. Sends a training
// preamble after reset, then shares the gearbox between two framed
// requesters, inserting periodic sync words and idle filler.
//   clk1, res_n           : clock, asynchronous active-low reset
//   gb_ready              : gearbox can accept a word decided this cycle
//   reqN_valid/data/last  : requester N word stream, framed by last
//   reqN_ready            : requester N word consumed this cycle (comb)
//   shift_in, data_in     : registered push into the gearbox
//   training              : registered, high while the preamble is sent
//   grant                 : registered one-hot frame owner, 0 when none
module gearbox_feed_ctrl
  import gearbox_pkg::*;
#(
  parameter int                TRAIN_LEN   = 16,
  parameter int                SYNC_PERIOD = 64,
  parameter logic [WORD_W-1:0] TRAIN_WORD  = TRAIN_WORD_DEF,
  parameter logic [WORD_W-1:0] SYNC_WORD   = SYNC_WORD_DEF,
  parameter logic [WORD_W-1:0] IDLE_WORD   = IDLE_WORD_DEF
) (
  input  logic              clk1,
  input  logic              res_n,
  input  logic              gb_ready,
  input  logic              req0_valid,
  input  logic [WORD_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [WORD_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              shift_in,
  output logic [WORD_W-1:0] data_in,
  output logic              training,
  output logic [1:0]        grant
);

  localparam int TW = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
  localparam int SW = $clog2(SYNC_PERIOD);
  localparam logic [TW-1:0] TRAIN_MAX = TW'(TRAIN_LEN - 1);
  localparam logic [SW-1:0] SYNC_MAX  = SW'(SYNC_PERIOD - 1);

  feed_state_e       state, state_nx;
  logic [TW-1:0]     train_cnt, train_cnt_nx;
  logic [SW-1:0]     sync_cnt, sync_cnt_nx;
  logic [1:0]        grant_nx;
  logic              emit;
  logic [WORD_W-1:0] word;
  logic              frame_done;
  logic [1:0]        pick;

  // Current owner's stream; grant is one-hot so bit 1 selects requester 1.
  logic              own_valid, own_last;
  logic [WORD_W-1:0] own_data;
  assign own_valid = grant[1] ? req1_valid : req0_valid;
  assign own_last  = grant[1] ? req1_last  : req0_last;
  assign own_data  = grant[1] ? req1_data  : req0_data;

  gearbox_rr_arb u_arb (
    .clk1    (clk1),
    .res_n   (res_n),
    .req     ({req1_valid, req0_valid}),
    .done    (frame_done),
    .done_id (grant[1]),
    .pick    (pick)
  );

  // Decision stage: everything is gated by gb_ready so a stalled gearbox
  // freezes the scheduler, counters included.
  always_comb begin
    state_nx     = state;
    train_cnt_nx = train_cnt;
    sync_cnt_nx  = sync_cnt;
    grant_nx     = grant;
    emit         = 1'b0;
    word         = IDLE_WORD;
    frame_done   = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (state)
      ST_TRAIN: begin
        if (gb_ready) begin
          emit = 1'b1;
          word = TRAIN_WORD;
          if (train_cnt == TRAIN_MAX) begin
            train_cnt_nx = '0;
            state_nx     = ST_ARB;
          end else begin
            train_cnt_nx = train_cnt + 1'b1;
          end
        end
      end
      ST_ARB: begin
        if (gb_ready) begin
          if (sync_cnt >= SYNC_MAX) begin
            // Sync has priority over a new frame; a sync deferred by a
            // long frame comes out here, right after its last word.
            emit        = 1'b1;
            word        = SYNC_WORD;
            sync_cnt_nx = '0;
          end else if (|pick) begin
            grant_nx = pick;
            state_nx = ST_BURST;
          end else begin
            emit        = 1'b1;
            word        = IDLE_WORD;
            sync_cnt_nx = sync_cnt + 1'b1;
          end
        end
      end
      ST_BURST: begin
        req0_ready = grant[0] & gb_ready & req0_valid;
        req1_ready = grant[1] & gb_ready & req1_valid;
        // A missing word is a bubble: nothing is pushed, no filler inserted.
        if (gb_ready && own_valid) begin
          emit = 1'b1;
          word = own_data;
          if (sync_cnt < SYNC_MAX) begin
            sync_cnt_nx = sync_cnt + 1'b1;
          end
          if (own_last) begin
            frame_done = 1'b1;
            grant_nx   = 2'b00;
            state_nx   = ST_ARB;
          end
        end
      end
      default: state_nx = ST_TRAIN;
    endcase
  end

  // Output stage: one-cycle registered push into the gearbox.
  always_ff @(posedge clk1 or negedge res_n) begin
    if (!res_n) begin
      state     <= ST_TRAIN;
      train_cnt <= '0;
      sync_cnt  <= '0;
      grant     <= 2'b00;
      shift_in  <= 1'b0;
      data_in   <= '0;
      training  <= 1'b1;
    end else begin
      state     <= state_nx;
      train_cnt <= train_cnt_nx;
      sync_cnt  <= sync_cnt_nx;
      grant     <= grant_nx;
      shift_in  <= emit;
      training  <= (state == ST_TRAIN);
      if (emit) begin
        data_in <= word;
      end
    end
  end

endmodule

// File: tb/tb_gearbox_feed_ctrl.sv
module tb_gearbox_feed_ctrl;

  logic        clk1 = 1'b0;
  logic        res_n, gb_ready;
  logic        req0_valid, req0_last, req0_ready;
  logic        req1_valid, req1_last, req1_ready;
  logic [15:0] req0_data, req1_data, data_in;
  logic        shift_in, training;
  logic [1:0]  grant;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk1 = ~clk1;

  gearbox_feed_ctrl #(
    .TRAIN_LEN   (16),
    .SYNC_PERIOD (8),
    .TRAIN_WORD  (16'hBC50),
    .SYNC_WORD   (16'h7E7E),
    .IDLE_WORD   (16'h0000)
  ) dut (
    .clk1       (clk1),
    .res_n      (res_n),
    .gb_ready   (gb_ready),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .shift_in   (shift_in),
    .data_in    (data_in),
    .training   (training),
    .grant      (grant)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and check the registered outputs #1 after the edge.
  task automatic cyc(input string tag, input logic s, input logic [15:0] d,
                     input logic [1:0] g, input logic t);
    @(posedge clk1);
    #1;
    chk({tag, ".shift"}, {31'd0, shift_in}, {31'd0, s});
    if (s) chk({tag, ".data"}, {16'd0, data_in}, {16'd0, d});
    chk({tag, ".grant"}, {30'd0, grant}, {30'd0, g});
    chk({tag, ".training"}, {31'd0, training}, {31'd0, t});
  endtask

  // Check the combinational ready outputs after the inputs have settled.
  task automatic rdy(input string tag, input logic r0, input logic r1);
    #1;
    chk({tag, ".ready0"}, {31'd0, req0_ready}, {31'd0, r0});
    chk({tag, ".ready1"}, {31'd0, req1_ready}, {31'd0, r1});
  endtask

  task automatic set0(input logic v, input logic [15:0] d, input logic l);
    req0_valid = v; req0_data = d; req0_last = l;
  endtask

  task automatic set1(input logic v, input logic [15:0] d, input logic l);
    req1_valid = v; req1_data = d; req1_last = l;
  endtask

  initial begin
    res_n = 1'b0;
    gb_ready = 1'b1;
    set0(1'b0, 16'h0000, 1'b0);
    set1(1'b0, 16'h0000, 1'b0);
    repeat (2) @(posedge clk1);
    #1;
    chk("rst.shift", {31'd0, shift_in}, 32'd0);
    chk("rst.data", {16'd0, data_in}, 32'd0);
    chk("rst.training", {31'd0, training}, 32'd1);
    chk("rst.grant", {30'd0, grant}, 32'd0);
    rdy("rst", 1'b0, 1'b0);
    res_n = 1'b1;

    // Training preamble, then idles until the first sync (period 8).
    for (int i = 0; i < 16; i++) cyc("t1.train", 1'b1, 16'hBC50, 2'b00, 1'b1);
    for (int i = 0; i < 7; i++)  cyc("t1.idle", 1'b1, 16'h0000, 2'b00, 1'b0);
    cyc("t1.sync", 1'b1, 16'h7E7E, 2'b00, 1'b0);

    // Single requester, 3-word frame.
    set0(1'b1, 16'hA001, 1'b0);
    cyc("t2.grant", 1'b0, 16'h0000, 2'b01, 1'b0); rdy("t2.g", 1'b1, 1'b0);
    cyc("t2.a1", 1'b1, 16'hA001, 2'b01, 1'b0);
    set0(1'b1, 16'hA002, 1'b0);                   rdy("t2.a1", 1'b1, 1'b0);
    cyc("t2.a2", 1'b1, 16'hA002, 2'b01, 1'b0);
    set0(1'b1, 16'hA003, 1'b1);                   rdy("t2.a2", 1'b1, 1'b0);
    cyc("t2.a3", 1'b1, 16'hA003, 2'b00, 1'b0);
    set0(1'b0, 16'h0000, 1'b0);                   rdy("t2.a3", 1'b0, 1'b0);
    cyc("t2.idle", 1'b1, 16'h0000, 2'b00, 1'b0);

    // Both requesters busy: frames alternate 1,0,1,0; sync lands between frames.
    set0(1'b1, 16'h0101, 1'b0);
    set1(1'b1, 16'h1101, 1'b0);
    cyc("t3.g1", 1'b0, 16'h0000, 2'b10, 1'b0);    rdy("t3.g1", 1'b0, 1'b1);
    cyc("t3.x1", 1'b1, 16'h1101, 2'b10, 1'b0);
    set1(1'b1, 16'h1102, 1'b1);                   rdy("t3.x1", 1'b0, 1'b1);
    cyc("t3.x2", 1'b1, 16'h1102, 2'b00, 1'b0);
    set1(1'b1, 16'h1201, 1'b0);                   rdy("t3.x2", 1'b0, 1'b0);
    cyc("t3.g0", 1'b0, 16'h0000, 2'b01, 1'b0);    rdy("t3.g0", 1'b1, 1'b0);
    cyc("t3.y1", 1'b1, 16'h0101, 2'b01, 1'b0);
    set0(1'b1, 16'h0102, 1'b1);                   rdy("t3.y1", 1'b1, 1'b0);
    cyc("t3.y2", 1'b1, 16'h0102, 2'b00, 1'b0);
    set0(1'b1, 16'h0201, 1'b0);                   rdy("t3.y2", 1'b0, 1'b0);
    cyc("t3.sync", 1'b1, 16'h7E7E, 2'b00, 1'b0);
    cyc("t3.g1b", 1'b0, 16'h0000, 2'b10, 1'b0);   rdy("t3.g1b", 1'b0, 1'b1);
    cyc("t3.z1", 1'b1, 16'h1201, 2'b10, 1'b0);
    set1(1'b1, 16'h1202, 1'b1);
    cyc("t3.z2", 1'b1, 16'h1202, 2'b00, 1'b0);
    set1(1'b0, 16'h0000, 1'b0);
    cyc("t3.g0b", 1'b0, 16'h0000, 2'b01, 1'b0);
    cyc("t3.w1", 1'b1, 16'h0201, 2'b01, 1'b0);
    set0(1'b1, 16'h0202, 1'b1);
    cyc("t3.w2", 1'b1, 16'h0202, 2'b00, 1'b0);
    set0(1'b0, 16'h0000, 1'b0);
    cyc("t3.idle", 1'b1, 16'h0000, 2'b00, 1'b0);

    // 8-word frame: the sync falling due inside it waits for the last word.
    set0(1'b1, 16'h0D00, 1'b0);
    cyc("t4.grant", 1'b0, 16'h0000, 2'b01, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc("t4.word", 1'b1, 16'(16'h0D00 + i), (i == 7) ? 2'b00 : 2'b01, 1'b0);
      if (i < 7) set0(1'b1, 16'(16'h0D00 + i + 1), (i == 6));
      else       set0(1'b0, 16'h0000, 1'b0);
    end
    cyc("t4.sync", 1'b1, 16'h7E7E, 2'b00, 1'b0);
    cyc("t4.idle", 1'b1, 16'h0000, 2'b00, 1'b0);

    // gb_ready toggling mid-frame plus one valid bubble.
    set1(1'b1, 16'h5A01, 1'b0);
    cyc("t5.grant", 1'b0, 16'h0000, 2'b10, 1'b0);
    gb_ready = 1'b0;                              rdy("t5.stall0", 1'b0, 1'b0);
    cyc("t5.gap0", 1'b0, 16'h0000, 2'b10, 1'b0);
    gb_ready = 1'b1;                              rdy("t5.go0", 1'b0, 1'b1);
    cyc("t5.w1", 1'b1, 16'h5A01, 2'b10, 1'b0);
    gb_ready = 1'b0; set1(1'b1, 16'h5A02, 1'b0);  rdy("t5.stall1", 1'b0, 1'b0);
    cyc("t5.gap1", 1'b0, 16'h0000, 2'b10, 1'b0);
    gb_ready = 1'b1; set1(1'b0, 16'h5A02, 1'b0);  rdy("t5.bubble", 1'b0, 1'b0);
    cyc("t5.gap2", 1'b0, 16'h0000, 2'b10, 1'b0);
    gb_ready = 1'b0; set1(1'b1, 16'h5A02, 1'b0);  rdy("t5.stall2", 1'b0, 1'b0);
    cyc("t5.gap3", 1'b0, 16'h0000, 2'b10, 1'b0);
    gb_ready = 1'b1;                              rdy("t5.go2", 1'b0, 1'b1);
    cyc("t5.w2", 1'b1, 16'h5A02, 2'b10, 1'b0);
    gb_ready = 1'b0; set1(1'b1, 16'h5A03, 1'b0);
    cyc("t5.gap4", 1'b0, 16'h0000, 2'b10, 1'b0);
    gb_ready = 1'b1;
    cyc("t5.w3", 1'b1, 16'h5A03, 2'b10, 1'b0);
    gb_ready = 1'b0; set1(1'b1, 16'h5A04, 1'b1);
    cyc("t5.gap5", 1'b0, 16'h0000, 2'b10, 1'b0);
    gb_ready = 1'b1;
    cyc("t5.w4", 1'b1, 16'h5A04, 2'b00, 1'b0);
    set1(1'b0, 16'h0000, 1'b0);
    cyc("t5.idle", 1'b1, 16'h0000, 2'b00, 1'b0);

    // Reset while word 2 of a 4-word frame is on data_in.
    set0(1'b1, 16'h6601, 1'b0);
    cyc("t6.grant", 1'b0, 16'h0000, 2'b01, 1'b0);
    cyc("t6.w1", 1'b1, 16'h6601, 2'b01, 1'b0);
    set0(1'b1, 16'h6602, 1'b0);
    cyc("t6.w2", 1'b1, 16'h6602, 2'b01, 1'b0);
    set0(1'b1, 16'h6603, 1'b0);
    #1 res_n = 1'b0;
    #1;
    chk("t6.rst.shift", {31'd0, shift_in}, 32'd0);
    chk("t6.rst.data", {16'd0, data_in}, 32'd0);
    chk("t6.rst.training", {31'd0, training}, 32'd1);
    chk("t6.rst.grant", {30'd0, grant}, 32'd0);
    chk("t6.rst.ready0", {31'd0, req0_ready}, 32'd0);
    @(posedge clk1);
    #1;
    chk("t6.hold.shift", {31'd0, shift_in}, 32'd0);
    set0(1'b1, 16'h6601, 1'b0);
    res_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc("t6.train", 1'b1, 16'hBC50, 2'b00, 1'b1);
      rdy("t6.train", 1'b0, 1'b0);
    end
    cyc("t6.regrant", 1'b0, 16'h0000, 2'b01, 1'b0); rdy("t6.regrant", 1'b1, 1'b0);
    cyc("t6.resend", 1'b1, 16'h6601, 2'b01, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gearbox_feed_ctrl.md
Name: gearbox_feed_ctrl

Overview:
Scheduler on the input-clock side of the 16-to-20 bit gearbox. It decides which 16-bit word enters the gearbox on each clk1 cycle, and drives the gearbox's shift_in/data_in pair.
- After reset it sends a training preamble.
- It then shares the gearbox between two framed requesters (round-robin, frame-locked).
- It inserts a periodic sync word and fills empty slots with idle words.

Parameters:
TRAIN_LEN, 16, number of training words sent after reset (>=1)
SYNC_PERIOD, 64, words between sync insertions (>=4)
TRAIN_WORD, 16'hBC50, training pattern word
SYNC_WORD, 16'h7E7E, sync marker word
IDLE_WORD, 16'h0000, filler word

Ports:
clk1  in  1  gearbox input-side clock; sole clock of this block
res_n  in  1  reset, asynchronous, active-low
gb_ready  in  1  gearbox has room for >=2 words (one cycle of slack for registered outputs)
req0_valid  in  1  requester 0 word available
req0_data  in  16  requester 0 word
req0_last  in  1  final word of requester 0 frame
req0_ready  out  1  requester 0 word consumed this cycle
req1_valid  in  1  requester 1 word available
req1_data  in  16  requester 1 word
req1_last  in  1  final word of requester 1 frame
req1_ready  out  1  requester 1 word consumed this cycle
shift_in  out  1  registered; word on data_in is pushed into the gearbox
data_in  out  16  registered word to the gearbox
training  out  1  registered; high while in TRAIN
grant  out  2  registered; one-hot owner of the current frame, 0 when none

Behaviour:
Reset values:
- Reset is asynchronous, active-low.
- shift_in=0, data_in=0, training=1, grant=0, req*_ready=0.
- FSM=TRAIN, train_cnt=0, sync_cnt=0, last_grant=1 (so requester 0 wins the first tie).

Emit rules:
- A word is emitted only in a cycle where gb_ready=1.
- shift_in/data_in update on the next clk1 edge: 1-cycle latency from decision to gearbox.
- When gb_ready=0: shift_in=0 next cycle and all counters hold.

FSM states:
- TRAIN:
  - Emit TRAIN_WORD and increment train_cnt.
  - After the TRAIN_LEN-th word: go to ARB, training=0 next cycle.
  - sync_cnt is not advanced in TRAIN.
- ARB, priority order:
  1. If sync_cnt >= SYNC_PERIOD-1: emit SYNC_WORD, sync_cnt=0, stay in ARB.
  2. Else if any reqN_valid: grant round-robin (requester != last_grant wins a tie). Set grant, go to BURST. No word is emitted in the grant cycle.
  3. Else: emit IDLE_WORD.
- BURST (owner g):
  - req_g_ready = gb_ready & req_g_valid, combinational.
  - On the handshake: emit req_g_data.
  - If req_g_last: last_grant=g, grant=0, go to ARB.
  - If req_g_valid=0: bubble. shift_in=0; no idle or sync word is inserted mid-frame.
  - The non-owner's ready is always 0.
- sync_cnt:
  - Increments on every emitted word outside TRAIN; saturates at SYNC_PERIOD-1.
  - A sync that falls due inside a frame is deferred to the next ARB cycle.
- req*_ready is 0 in TRAIN and ARB.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is abandoned and the requester must resend it.
- If a single-word frame has valid and last together: one word, then back to ARB.

Decomposition:
- Shared package gearbox_pkg holds:
  - Word width constant (16) and gearbox output width (20).
  - Default TRAIN_WORD, SYNC_WORD and IDLE_WORD values.
  - FSM state enum {TRAIN, ARB, BURST}.
- One natural sub-module: gearbox_rr_arb, the 2-way round-robin arbiter with last_grant register.
- The FSM and counters stay in the top level.

Test Plan:
1. Reset release with gb_ready=1 and no requests -> 16 cycles of shift_in=1 carrying 16'hBC50 with training=1, then training=0 and 16'h0000 idle words.
2. req0 sends a 3-word frame A1..A3 while req1 is idle -> one grant cycle with shift_in=0, then A1,A2,A3 on consecutive cycles; req0_ready high exactly 3 cycles; grant=2'b01 during the frame.
3. Both requesters hold back-to-back 2-word frames -> frames interleave 0,1,0,1; no two consecutive frames from the same requester.
4. SYNC_PERIOD=8 with continuous traffic -> 16'h7E7E appears after at most 7 non-sync words, only between frames; an 8-word frame delays it until after its last word.
5. Toggle gb_ready 1/0 every cycle mid-frame, plus one req_valid=0 bubble -> no word lost or duplicated; shift_in=0 in every gap; no idle word inside the frame.
6. Pull res_n low while word 2 of a 4-word frame is in flight -> outputs go to reset values immediately; after release, TRAIN restarts with a 16-word preamble.
